multdiv32: RTL and testbench
============================

# multdiv32

Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS datapath. It sits beside the ALU, downstream of the register-file decoder: it consumes the decoder's `read_data_1`/`read_data_2` and the current instruction word, and supplies the `hi`/`lo` values the decoder writes back for `mfhi`/`mflo`. While an operation is in flight it raises `busy` so the controller can freeze the PC.

## Interface
- `DIV_ZERO_LO`, default 32'hFFFFFFFF: value written to LO on divide by zero.
- `clock`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `Issue`  in  1  instruction in `Instruction` is valid this cycle. Driven by control while the PC is not stalled.
- `Instruction`  in  32  current instruction; decoded when [31:26]==0, using funct [5:0].
- `read_data_1`  in  32  rs operand (dividend / multiplicand / mthi-mtlo source).
- `read_data_2`  in  32  rt operand (divisor / multiplier).
- `busy`  out  1  registered; high while an operation is in flight.
- `done`  out  1  registered one-cycle pulse in the cycle after HI/LO are written by mult/div.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- Recognised funct codes: mult 011000, multu 011001, div 011010, divu 011011, mthi 010001, mtlo 010011. Everything else is ignored.
- Accept condition: `Issue` && !`busy` && recognised op. While `busy`, `Issue` is ignored; the controller must not issue.
- mthi/mtlo: written from `read_data_1` on the accept edge. No busy, no `done`.
- States are IDLE, MUL, DIV and FIX. `busy` = (state != IDLE), registered.
- On mult/div accept, operands are latched. For signed ops, magnitudes and result signs are recorded; the state then goes to MUL or DIV with iteration counter = 0.
- MUL: shift-add, one multiplier bit per cycle, 64-bit accumulator. After 32 iterations the state goes to FIX.
- DIV: restoring division, one quotient bit per cycle. After 32 iterations the state goes to FIX.
- FIX: applies sign correction, writes {HI,LO}, asserts `done` next cycle, returns to IDLE.
- Multiply result: HI = product[63:32], LO = product[31:0], modulo 2^64.
- Divide result: LO = quotient, truncated toward zero. HI = remainder, with the sign of the dividend.
- Signed 0x80000000 / -1 gives LO = 0x80000000, HI = 0. No trap.
- Divide by zero is detected at accept and skips DIV: the state goes straight to FIX with HI = `read_data_1` and LO = `DIV_ZERO_LO`.
- `hi`/`lo` keep their old values throughout an operation and change only on the FIX edge.

## Timing
- Reset values: `busy` 0, `done` 0, `hi` 0, `lo` 0, state IDLE, counter 0.
- Reset mid-operation aborts the operation immediately. HI/LO are cleared and no `done` is produced.
- Iterative mult/div, with accept at edge E0:
  - iterations run on E1..E32;
  - FIX writes HI/LO on E33;
  - `busy` is high from after E0 through E33 (33 cycles);
  - `done` is high for the cycle after E33;
  - new HI/LO are readable in that same cycle.
- Divide by zero: FIX on E1, so `busy` lasts 1 cycle and `done` follows E1.
- mthi/mtlo: the new value is visible the cycle after the accept edge.
- Back-to-back: a new issue is accepted in the first cycle `busy` is low, which is the `done` cycle.

## Configuration
- `MULTDIV_FAST_MUL_EN` defined:
  - mult/multu compute a combinational 64-bit product and write HI/LO on the accept edge;
  - `busy` is never raised for multiply;
  - `done` pulses the cycle after accept.
  - Divide behaviour is unchanged.
- Undefined: multiply uses the 33-cycle iterative path above.

## Test plan
- Reset, then multu with rs=0xFFFFFFFF, rt=2: `busy` for 33 cycles, then HI=0x00000001, LO=0xFFFFFFFE, `done` for 1 cycle.
- mult with rs=0xFFFFFFFF, rt=2: HI=0xFFFFFFFF, LO=0xFFFFFFFE. With `MULTDIV_FAST_MUL_EN`, the same result appears 1 cycle after accept and `busy` stays 0.
- div with rs=-8 (0xFFFFFFF8), rt=3: LO=0xFFFFFFFE, HI=0xFFFFFFFE. divu with rs=100, rt=7: LO=14, HI=2.
- div with rs=0x80000000, rt=0xFFFFFFFF: LO=0x80000000, HI=0. divu with rs=5, rt=0: `busy` 1 cycle, HI=5, LO=0xFFFFFFFF.
- Start div with rs=100, rt=7; pulse mthi (rs=0x1234) at cycle 10: the mthi is ignored. Assert `reset` at cycle 20: `busy` 0, HI=LO=0, no `done`.
- mtlo with rs=0xDEADBEEF while idle: LO=0xDEADBEEF next cycle, `busy` and `done` stay 0, HI unchanged. Back-to-back divu issued in the `done` cycle is accepted.

Source files
------------

// File: rtl/multdiv32.sv
// ---------------------------------------------------------------------------
// multdiv32 -- iterative multiply/divide unit with architectural HI/LO.
//
// Sits beside the ALU of the single-cycle MIPS datapath. It decodes SPECIAL
// (opcode 0) mult/multu/div/divu/mthi/mtlo and owns the HI/LO registers.
// Multiply is shift-add and divide is restoring, one bit per cycle. A final
// FIX cycle applies sign correction and writes {HI,LO}.
//
// Optional feature: define MULTDIV_FAST_MUL_EN to compute mult/multu with a
// combinational 64-bit product. HI/LO are then written on the accept edge and
// busy is never raised for multiply. Divide behaviour is unchanged.
//
// Parameters
//   DIV_ZERO_LO  value written to LO on divide by zero
// Ports
//   clock        system clock, rising edge
//   reset        synchronous active-high reset, clears all state
//   Issue        Instruction is valid this cycle
//   Instruction  current instruction word (funct in [5:0])
//   read_data_1  rs operand: dividend / multiplicand / mthi-mtlo source
//   read_data_2  rt operand: divisor / multiplier
//   busy         registered, high while an operation is in flight
//   done         registered one-cycle pulse after HI/LO are written by mult/div
//   hi, lo       architectural HI and LO registers
// ---------------------------------------------------------------------------
module multdiv32 #(
    parameter logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        Issue,
    input  logic [31:0] Instruction,
    input  logic [31:0] read_data_1,
    input  logic [31:0] read_data_2,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t      state;
    logic [4:0]  count;
    // MUL: {partial product high, multiplier shifting out / product low}
    // DIV: {partial remainder, dividend shifting out / quotient shifting in}
    logic [63:0] acc;
    logic [31:0] operand;   // multiplicand or divisor magnitude
    logic        neg_q;     // product or quotient must be negated in FIX
    logic        neg_r;     // remainder must be negated in FIX
    logic        is_div;
    logic        div_zero;

    // ---------------------------------------------------------------------
    // Decode
    // ---------------------------------------------------------------------
    logic [5:0] funct;
    logic       special;
    logic       accept;
    logic       op_mult, op_div, op_mthi, op_mtlo;
    logic       is_signed;

    assign funct     = Instruction[5:0];
    assign special   = (Instruction[31:26] == 6'd0);
    assign accept    = Issue && !busy && special;
    assign op_mult   = accept && (funct == F_MULT || funct == F_MULTU);
    assign op_div    = accept && (funct == F_DIV  || funct == F_DIVU);
    assign op_mthi   = accept && (funct == F_MTHI);
    assign op_mtlo   = accept && (funct == F_MTLO);
    // Signed variants have funct[0] clear (mult/div), unsigned have it set.
    assign is_signed = ~funct[0];

    logic unused_instr_bits;
    assign unused_instr_bits = ^Instruction[25:6];

    // Operand magnitudes. |0x80000000| is 0x80000000 read as unsigned, which
    // makes the signed-overflow divide fall out naturally with no trap.
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;

    assign a_neg = is_signed & read_data_1[31];
    assign b_neg = is_signed & read_data_2[31];
    assign a_mag = a_neg ? -read_data_1 : read_data_1;
    assign b_mag = b_neg ? -read_data_2 : read_data_2;

    // ---------------------------------------------------------------------
    // Iteration and fix-up datapath
    // ---------------------------------------------------------------------
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic        div_ge;
    logic [31:0] div_rem_next;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        mul_sum      = {1'b0, acc[63:32]};
        if (acc[0])
            mul_sum = {1'b0, acc[63:32]} + {1'b0, operand};

        div_shift    = {acc[63:32], acc[31]};
        div_diff     = div_shift - {1'b0, operand};
        div_ge       = (div_shift >= {1'b0, operand});
        div_rem_next = div_ge ? div_diff[31:0] : div_shift[31:0];

        prod_fix     = neg_q ? -acc : acc;
        quo_fix      = neg_q ? -acc[31:0] : acc[31:0];
        rem_fix      = neg_r ? -acc[63:32] : acc[63:32];
    end

`ifdef MULTDIV_FAST_MUL_EN
    logic [63:0] ext_a, ext_b, fast_prod;

    // Lower 64 bits of the product of extended operands give the correct
    // signed or unsigned result.
    assign ext_a     = is_signed ? {{32{read_data_1[31]}}, read_data_1} : {32'd0, read_data_1};
    assign ext_b     = is_signed ? {{32{read_data_2[31]}}, read_data_2} : {32'd0, read_data_2};
    assign fast_prod = ext_a * ext_b;
`endif

    // ---------------------------------------------------------------------
    // Control and state
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            count    <= 5'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            acc      <= 64'd0;
            operand  <= 32'd0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (op_mthi) hi <= read_data_1;
                    if (op_mtlo) lo <= read_data_1;
                    if (op_mult) begin
`ifdef MULTDIV_FAST_MUL_EN
                        hi   <= fast_prod[63:32];
                        lo   <= fast_prod[31:0];
                        done <= 1'b1;
`else
                        state    <= MUL;
                        busy     <= 1'b1;
                        count    <= 5'd0;
                        acc      <= {32'd0, b_mag};
                        operand  <= a_mag;
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= 1'b0;
                        is_div   <= 1'b0;
                        div_zero <= 1'b0;
`endif
                    end
                    if (op_div) begin
                        busy   <= 1'b1;
                        count  <= 5'd0;
                        is_div <= 1'b1;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        if (read_data_2 == 32'd0) begin
                            // Raw rs is parked in the HI half for FIX.
                            state    <= FIX;
                            div_zero <= 1'b1;
                            acc      <= {read_data_1, 32'd0};
                        end else begin
                            state    <= DIV;
                            div_zero <= 1'b0;
                            acc      <= {32'd0, a_mag};
                            operand  <= b_mag;
                        end
                    end
                end

                MUL: begin
                    acc   <= {mul_sum, acc[31:1]};
                    count <= count + 5'd1;
                    if (count == 5'd31) state <= FIX;
                end

                DIV: begin
                    acc   <= {div_rem_next, acc[30:0], div_ge};
                    count <= count + 5'd1;
                    if (count == 5'd31) state <= FIX;
                end

                FIX: begin
                    if (div_zero) begin
                        hi <= acc[63:32];
                        lo <= DIV_ZERO_LO;
                    end else if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[63:32];
                        lo <= prod_fix[31:0];
                    end
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    count <= 5'd0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv32.sv
// ---------------------------------------------------------------------------
// tb_multdiv32 -- directed self-checking bench for multdiv32.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_multdiv32;

    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

`ifdef MULTDIV_FAST_MUL_EN
    localparam int MUL_CYCLES = 0;
`else
    localparam int MUL_CYCLES = 33;
`endif
    localparam int DIV_CYCLES = 33;

    logic        clock;
    logic        reset;
    logic        Issue;
    logic [31:0] Instruction;
    logic [31:0] read_data_1;
    logic [31:0] read_data_2;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    multdiv32 dut (
        .clock       (clock),
        .reset       (reset),
        .Issue       (Issue),
        .Instruction (Instruction),
        .read_data_1 (read_data_1),
        .read_data_2 (read_data_2),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one instruction for exactly one cycle; returns at the falling
    // edge just after the accept edge.
    task automatic issue_op(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        Issue       = 1'b1;
        Instruction = instr;
        read_data_1 = a;
        read_data_2 = b;
        @(negedge clock);
        Issue       = 1'b0;
        Instruction = 32'd0;
    endtask

    function automatic logic [31:0] special(input logic [5:0] f);
        return {26'd0, f};
    endfunction

    // Count busy cycles (bounded) and note whether HI/LO moved while busy.
    // Returns at the first falling edge with busy low.
    task automatic wait_idle(output int cycles, output bit stable);
        logic [31:0] hi0, lo0;
        hi0    = hi;
        lo0    = lo;
        cycles = 0;
        stable = 1'b1;
        while (busy === 1'b1 && cycles < 200) begin
            if (hi !== hi0 || lo !== lo0) stable = 1'b0;
            cycles++;
            @(negedge clock);
        end
    endtask

    // Run a mult/div and check busy length, stability, done and HI/LO.
    task automatic run_and_check(input string name, input logic [5:0] f,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input int exp_cycles,
                                 input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cycles;
        bit stable;
        issue_op(special(f), a, b);
        wait_idle(cycles, stable);
        checks++;
        if (cycles !== exp_cycles) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, cycles, exp_cycles);
        end
        checks++;
        if (stable !== 1'b1) begin
            errors++;
            $display("FAIL %s hilo_stable: got %0b expected 1", name, stable);
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s done: got %0b expected 1", name, done);
        end
        checks++;
        if (hi !== exp_hi) begin
            errors++;
            $display("FAIL %s hi: got %h expected %h", name, hi, exp_hi);
        end
        checks++;
        if (lo !== exp_lo) begin
            errors++;
            $display("FAIL %s lo: got %h expected %h", name, lo, exp_lo);
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse_width: got %0b expected 0", name, done);
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        Issue       = 1'b0;
        Instruction = 32'd0;
        read_data_1 = 32'd0;
        read_data_2 = 32'd0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            errors++;
            $display("FAIL reset_state: got busy=%0b done=%0b hi=%h lo=%h expected all 0",
                     busy, done, hi, lo);
        end
    endtask

    task automatic test_multu();
        run_and_check("multu_ffffffff_x2", F_MULTU, 32'hFFFF_FFFF, 32'd2,
                      MUL_CYCLES, 32'h0000_0001, 32'hFFFF_FFFE);
    endtask

    task automatic test_mult();
        run_and_check("mult_m1_x2", F_MULT, 32'hFFFF_FFFF, 32'd2,
                      MUL_CYCLES, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_and_check("mult_7_xm3", F_MULT, 32'd7, 32'hFFFF_FFFD,
                      MUL_CYCLES, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_and_check("mult_min_x_min", F_MULT, 32'h8000_0000, 32'h8000_0000,
                      MUL_CYCLES, 32'h4000_0000, 32'h0000_0000);
    endtask

    task automatic test_div();
        run_and_check("div_m8_by_3", F_DIV, 32'hFFFF_FFF8, 32'd3,
                      DIV_CYCLES, 32'hFFFF_FFFE, 32'hFFFF_FFFE);
        run_and_check("div_7_by_m2", F_DIV, 32'd7, 32'hFFFF_FFFE,
                      DIV_CYCLES, 32'h0000_0001, 32'hFFFF_FFFD);
    endtask

    task automatic test_divu();
        run_and_check("divu_100_by_7", F_DIVU, 32'd100, 32'd7,
                      DIV_CYCLES, 32'd2, 32'd14);
    endtask

    task automatic test_div_overflow();
        run_and_check("div_min_by_m1", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
                      DIV_CYCLES, 32'h0000_0000, 32'h8000_0000);
    endtask

    task automatic test_div_zero();
        run_and_check("divu_5_by_0", F_DIVU, 32'd5, 32'd0,
                      1, 32'd5, 32'hFFFF_FFFF);
    endtask

    // div in flight, mthi attempted mid-operation, then reset aborts it.
    task automatic test_abort();
        logic [31:0] hi_before;
        bit          done_seen;
        hi_before = hi;
        issue_op(special(F_DIV), 32'd100, 32'd7);
        repeat (8) @(negedge clock);
        Issue       = 1'b1;
        Instruction = special(F_MTHI);
        read_data_1 = 32'h0000_1234;
        @(negedge clock);
        Issue       = 1'b0;
        Instruction = 32'd0;
        checks++;
        if (hi !== hi_before) begin
            errors++;
            $display("FAIL abort_mthi_ignored: got hi=%h expected %h", hi, hi_before);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_still_busy: got %0b expected 1", busy);
        end
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if ({busy, hi, lo} !== 65'd0) begin
            errors++;
            $display("FAIL abort_reset_state: got busy=%0b hi=%h lo=%h expected all 0",
                     busy, hi, lo);
        end
        done_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) done_seen = 1'b1;
            @(negedge clock);
        end
        checks++;
        if (done_seen !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: got activity=%0b expected 0", done_seen);
        end
    endtask

    task automatic test_mtlo();
        logic [31:0] hi_before;
        hi_before = hi;
        issue_op(special(F_MTLO), 32'hDEAD_BEEF, 32'd0);
        checks++;
        if (lo !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL mtlo_lo: got %h expected deadbeef", lo);
        end
        checks++;
        if (hi !== hi_before) begin
            errors++;
            $display("FAIL mtlo_hi_unchanged: got %h expected %h", hi, hi_before);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mtlo_no_busy_done: got busy=%0b done=%0b expected 0 0", busy, done);
        end
        issue_op(special(F_MTHI), 32'hCAFE_0001, 32'd0);
        checks++;
        if (hi !== 32'hCAFE_0001 || lo !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL mthi_hi: got hi=%h lo=%h expected cafe0001 deadbeef", hi, lo);
        end
    endtask

    // Non-SPECIAL opcode with a multiply funct must be ignored.
    task automatic test_ignored();
        issue_op({6'h23, 20'd0, F_MULT}, 32'd3, 32'd3);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'hCAFE_0001 || lo !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL ignored_opcode: got busy=%0b done=%0b hi=%h lo=%h expected 0 0 cafe0001 deadbeef",
                     busy, done, hi, lo);
        end
    endtask

    // Second divu driven during the done cycle of the first.
    task automatic test_back_to_back();
        int cycles;
        bit stable;
        issue_op(special(F_DIVU), 32'd100, 32'd7);
        wait_idle(cycles, stable);
        checks++;
        if (done !== 1'b1 || lo !== 32'd14 || hi !== 32'd2) begin
            errors++;
            $display("FAIL b2b_first: got done=%0b hi=%h lo=%h expected 1 2 14", done, hi, lo);
        end
        Issue       = 1'b1;
        Instruction = special(F_DIVU);
        read_data_1 = 32'd9;
        read_data_2 = 32'd2;
        @(negedge clock);
        Issue       = 1'b0;
        Instruction = 32'd0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accepted: got busy=%0b expected 1", busy);
        end
        wait_idle(cycles, stable);
        checks++;
        if (cycles !== DIV_CYCLES) begin
            errors++;
            $display("FAIL b2b_busy_cycles: got %0d expected %0d", cycles, DIV_CYCLES);
        end
        checks++;
        if (done !== 1'b1 || hi !== 32'd1 || lo !== 32'd4) begin
            errors++;
            $display("FAIL b2b_second: got done=%0b hi=%h lo=%h expected 1 1 4", done, hi, lo);
        end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_divu();
        test_div_overflow();
        test_div_zero();
        test_abort();
        test_mtlo();
        test_ignored();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within 200000 time units");
        $fatal(1, "watchdog timeout");
    end

endmodule
